// File: rtl/scanline_ctrl_if.sv
// Scanline controller bus: frame timing inputs, cfg requests, and datapath controls.
interface scanline_ctrl_if;
  logic       VSYNC_i;
  logic       DE_i;
  logic       FIELD_i;
  logic       cfg_sl_en_i;
  logic       cfg_sl_thickness_i;
  logic [1:0] cfg_sl_profile_i;
  logic [7:0] cfg_sl_strength_i;
  logic [4:0] cfg_sl_bloom_i;
  logic [11:0] cfg_vstep_i;
  logic [7:0] cfg_vphase_i;
  logic       sl_en_o;
  logic       sl_thickness_o;
  logic [1:0] sl_profile_o;
  logic [7:0] sl_strength_o;
  logic [4:0] sl_bloom_o;
  logic [7:0] sl_rel_pos_o;
  logic       frame_locked_o;

  modport master (
    output VSYNC_i, DE_i, FIELD_i, cfg_sl_en_i, cfg_sl_thickness_i, cfg_sl_profile_i,
           cfg_sl_strength_i, cfg_sl_bloom_i, cfg_vstep_i, cfg_vphase_i,
    input  sl_en_o, sl_thickness_o, sl_profile_o, sl_strength_o, sl_bloom_o,
           sl_rel_pos_o, frame_locked_o
  );
  modport slave (
    input  VSYNC_i, DE_i, FIELD_i, cfg_sl_en_i, cfg_sl_thickness_i, cfg_sl_profile_i,
           cfg_sl_strength_i, cfg_sl_bloom_i, cfg_vstep_i, cfg_vphase_i,
    output sl_en_o, sl_thickness_o, sl_profile_o, sl_strength_o, sl_bloom_o,
           sl_rel_pos_o, frame_locked_o
  );
endinterface

// File: rtl/scanline_ctrl.sv
// Scanline controller: frame-synchronous cfg shadowing and vertical phase accumulation.
// Optional SCANLINE_CTRL_FIELD_OFFSET_EN adds a half-line phase offset for odd fields.
module scanline_ctrl #(
  parameter int ACC_W = 16
) (
  input logic VCLK_i,
  input logic VRST_i,
  scanline_ctrl_if.slave sif
);
  typedef enum logic [1:0] {WAIT_VS, VBLANK, ACTIVE} state_t;

  state_t     state, state_nxt;
  logic       vsync_q, de_q;
  logic       vs_rise, de_fall;
  logic       framed, step;
  logic [ACC_W-1:0] acc, reload;

  logic       sh_en, sh_thick;
  logic [1:0] sh_prof;
  logic [7:0] sh_str;
  logic [4:0] sh_bloom;
  logic [11:0] sh_vstep;

  logic       en_q, thick_q, locked_q;
  logic [1:0] prof_q;
  logic [7:0] str_q;
  logic [4:0] bloom_q;

  assign vs_rise = sif.VSYNC_i & ~vsync_q;
  assign de_fall = ~sif.DE_i & de_q;

`ifdef SCANLINE_CTRL_FIELD_OFFSET_EN
  assign reload = ACC_W'(sif.cfg_vphase_i) + ACC_W'(sif.FIELD_i ? 8'h80 : 8'h00);
`else
  logic unused_field;
  assign unused_field = sif.FIELD_i;
  assign reload = ACC_W'(sif.cfg_vphase_i);
`endif

  always_ff @(posedge VCLK_i or posedge VRST_i) begin
    if (VRST_i) state <= WAIT_VS;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_VS: if (vs_rise) state_nxt = VBLANK;
      VBLANK:  if (!vs_rise && sif.DE_i) state_nxt = ACTIVE;
      ACTIVE:  if (vs_rise) state_nxt = VBLANK;
      default: state_nxt = WAIT_VS;
    endcase
  end

  // A frame start on the same edge as a line end reloads and suppresses the step.
  always_comb begin
    framed = (state != WAIT_VS);
    step   = de_fall & ~vs_rise & (state == ACTIVE);
  end

  always_ff @(posedge VCLK_i or posedge VRST_i) begin
    if (VRST_i) begin
      vsync_q  <= 1'b0;
      de_q     <= 1'b0;
      acc      <= '0;
      sh_en    <= 1'b0;
      sh_thick <= 1'b0;
      sh_prof  <= '0;
      sh_str   <= '0;
      sh_bloom <= '0;
      sh_vstep <= '0;
      locked_q <= 1'b0;
      en_q     <= 1'b0;
      thick_q  <= 1'b0;
      prof_q   <= '0;
      str_q    <= '0;
      bloom_q  <= '0;
    end else begin
      vsync_q <= sif.VSYNC_i;
      de_q    <= sif.DE_i;
      if (vs_rise) begin
        sh_en    <= sif.cfg_sl_en_i;
        sh_thick <= sif.cfg_sl_thickness_i;
        sh_prof  <= sif.cfg_sl_profile_i;
        sh_str   <= sif.cfg_sl_strength_i;
        sh_bloom <= sif.cfg_sl_bloom_i;
        sh_vstep <= sif.cfg_vstep_i;
        acc      <= reload;
        locked_q <= 1'b1;
      end else if (step) begin
        acc <= acc + ACC_W'(sh_vstep);
      end
      en_q    <= sh_en & framed & (sh_vstep != 12'h000);
      thick_q <= sh_thick;
      prof_q  <= sh_prof;
      str_q   <= sh_str;
      bloom_q <= sh_bloom;
    end
  end

  assign sif.sl_en_o        = en_q;
  assign sif.sl_thickness_o = thick_q;
  assign sif.sl_profile_o   = prof_q;
  assign sif.sl_strength_o  = str_q;
  assign sif.sl_bloom_o     = bloom_q;
  assign sif.sl_rel_pos_o   = acc[7:0];
  assign sif.frame_locked_o = locked_q;
endmodule

// File: doc/scanline_ctrl.md
SCANLINE_CTRL -- requirements
Module: scanline_ctrl

Interface
REQ-001 SHALL have parameter ACC_W, default 16, vertical phase accumulator width; 8 fractional bits, minimum 12.
REQ-002 SHALL have ports: VCLK_i  in  1  video clock; all logic in this single domain.
REQ-003 SHALL have ports: VRST_i  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: VSYNC_i  in  1  vertical sync, active high; rising edge = frame start.
REQ-005 SHALL have ports: DE_i  in  1  data enable; falling edge = end of output line.
REQ-006 SHALL have ports: FIELD_i  in  1  interlace field ID; 1 = odd.
REQ-007 SHALL have ports: cfg_sl_en_i  in  1  scanline enable request.
REQ-008 SHALL have ports: cfg_sl_thickness_i  in  1  thickness select.
REQ-009 SHALL have ports: cfg_sl_profile_i  in  2  profile select.
REQ-010 SHALL have ports: cfg_sl_strength_i  in  8  scanline strength.
REQ-011 SHALL have ports: cfg_sl_bloom_i  in  5  bloom factor.
REQ-012 SHALL have ports: cfg_vstep_i  in  12  input lines per output line, unsigned 4.8 fixed point.
REQ-013 SHALL have ports: cfg_vphase_i  in  8  initial phase at frame start, 0.8 fixed point.
REQ-014 SHALL have ports: sl_en_o, sl_thickness_o, sl_profile_o[1:0], sl_strength_o[7:0], sl_bloom_o[4:0]  out  registered scanline datapath controls.
REQ-015 SHALL have ports: sl_rel_pos_o  out  8  position within current input line; constant for a whole output line.
REQ-016 SHALL have ports: frame_locked_o  out  1  high once a frame start has been seen since reset.

Function
REQ-017 SHALL register VSYNC_i and DE_i once internally and detect edges by comparing each new sample with the previous one.
REQ-018 SHALL implement states WAIT_VS (after reset), VBLANK and ACTIVE.
REQ-019 State transitions SHALL be: WAIT_VS->VBLANK on VSYNC rise; VBLANK->ACTIVE on DE_i sampled high; ACTIVE->VBLANK on VSYNC rise.
REQ-020 On VSYNC rise, the block SHALL latch all cfg_* inputs into shadow registers; outputs SHALL be driven only from shadows, so mid-frame cfg changes take effect next frame.
REQ-021 On VSYNC rise, the accumulator SHALL load {0, cfg_vphase_i} (plus offset per REQ-033).
REQ-022 On each DE falling edge while in ACTIVE, the accumulator SHALL advance by acc <= acc + shadow_vstep, wrapping modulo 2^ACC_W.
REQ-023 sl_rel_pos_o SHALL equal acc[7:0]; it updates on the same VCLK_i edge that first samples the triggering VSYNC rise or DE fall (1-cycle latency from input change).
REQ-024 sl_en_o SHALL be shadow_sl_en AND (state != WAIT_VS) AND (shadow_vstep != 0).
REQ-025 If VSYNC rise and DE fall are detected on the same edge, VSYNC SHALL win: reload, no step.
REQ-026 DE falling edges in WAIT_VS or VBLANK SHALL NOT advance the accumulator.
REQ-027 frame_locked_o SHALL rise on the first VSYNC rise after reset and stay high until reset.
REQ-028 All other outputs SHALL be registered.

Reset
REQ-029 While VRST_i is high, the state SHALL be WAIT_VS and the accumulator, shadows and all outputs SHALL be 0.
REQ-030 Assertion of VRST_i SHALL take effect immediately, regardless of the clock.
REQ-031 After VRST_i deasserts, nothing SHALL change until the first VSYNC rise.
REQ-032 Reset asserted mid-frame SHALL abort the frame; the first VSYNC rise after release restarts sequencing.

Configuration
REQ-033 With macro SCANLINE_CTRL_FIELD_OFFSET_EN defined, the reload value SHALL be cfg_vphase_i + (FIELD_i ? 8'h80 : 0), computed modulo 2^ACC_W.
REQ-034 Without SCANLINE_CTRL_FIELD_OFFSET_EN, FIELD_i SHALL be ignored and the reload value SHALL be cfg_vphase_i.

Verification
REQ-035 Bench SHALL cover: reset release, cfg_sl_en_i=1, no VSYNC for 1000 cycles -> sl_en_o=0, frame_locked_o=0, sl_rel_pos_o=0.
REQ-036 Bench SHALL cover: vstep=12'h100, vphase=8'h40, 4 lines -> sl_rel_pos_o stays 8'h40 after every line end.
REQ-037 Bench SHALL cover: vstep=12'h0AB (~2/3), vphase=0 -> sl_rel_pos_o sequence 00, AB, 56, 01, AC after successive DE falls.
REQ-038 Bench SHALL cover: cfg_sl_strength_i changed 8'h40->8'hC0 mid-frame -> sl_strength_o stays 8'h40 until the next VSYNC rise +1 cycle.
REQ-039 Bench SHALL cover: VSYNC rise and DE fall on the same cycle, vphase=8'h10 -> sl_rel_pos_o=8'h10 with no step applied.
REQ-040 Bench SHALL cover: macro defined, FIELD_i=1, vphase=8'h10 -> sl_rel_pos_o=8'h90 at frame start; macro undefined -> 8'h10.
